// File: rtl/uart_frac_baud_gen.sv
// Fractional-N baud tick generator: oversample tick every div_int + div_frac/2^FRAC_W clocks
// on average, bit tick every OVERSAMPLE oversample ticks, with glitch-free divisor reload.
module uart_frac_baud_gen #(
    parameter int unsigned DIV_W            = 16,
    parameter int unsigned FRAC_W           = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = 27,
    parameter int unsigned DEFAULT_DIV_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              load_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              tick_os_o,
    output logic              tick_bit_o,
    output logic              load_ack_o,
    output logic              div_busy_o
);
    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_TOP  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [OS_W-1:0]   os_q, os_d;
    logic [DIV_W-1:0]  int_q, int_d, pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] frac_q, frac_d, pend_frac_q, pend_frac_d;
    logic              busy_q, busy_d;
    logic              tick_os_q, tick_os_d;
    logic              tick_bit_q, tick_bit_d;
    logic              ack_q, ack_d;

    logic [CNT_W-1:0]  eff;
    logic [CNT_W-1:0]  period_m1;
    logic [FRAC_W:0]   acc_sum;
    logic              wrap;
    logic              apply;

    // cnt is one bit wider than the divisor so a carry-extended max period still fits
    assign eff       = (int_q == '0) ? CNT_W'(1) : {1'b0, int_q};
    assign period_m1 = eff + CNT_W'(ext_q) - CNT_W'(1);
    assign wrap      = en_i & ~sync_i & (cnt_q == period_m1);
    assign acc_sum   = {1'b0, acc_q} + {1'b0, frac_q};
    assign apply     = (load_i | busy_q) & (sync_i | ~en_i | wrap);

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ext_d       = ext_q;
        os_d        = os_q;
        int_d       = int_q;
        frac_d      = frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        busy_d      = busy_q;
        tick_os_d   = 1'b0;
        tick_bit_d  = 1'b0;
        ack_d       = 1'b0;

        if (sync_i) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
            os_d  = OS_HALF;
        end else if (en_i) begin
            if (wrap) begin
                cnt_d      = '0;
                tick_os_d  = 1'b1;
                acc_d      = acc_sum[FRAC_W-1:0];
                ext_d      = acc_sum[FRAC_W];
                tick_bit_d = (os_q == '0);
                os_d       = (os_q == '0) ? OS_TOP : os_q - OS_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A load coinciding with the apply point bypasses the pending registers
        if (apply) begin
            int_d  = load_i ? div_int_i  : pend_int_q;
            frac_d = load_i ? div_frac_i : pend_frac_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end else if (load_i) begin
            pend_int_d  = div_int_i;
            pend_frac_d = div_frac_i;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            ext_q       <= 1'b0;
            os_q        <= OS_TOP;
            int_q       <= DIV_W'(DEFAULT_DIV_INT);
            frac_q      <= FRAC_W'(DEFAULT_DIV_FRAC);
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            busy_q      <= 1'b0;
            tick_os_q   <= 1'b0;
            tick_bit_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ext_q       <= ext_d;
            os_q        <= os_d;
            int_q       <= int_d;
            frac_q      <= frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            busy_q      <= busy_d;
            tick_os_q   <= tick_os_d;
            tick_bit_q  <= tick_bit_d;
            ack_q       <= ack_d;
        end
    end

    assign tick_os_o  = tick_os_q;
    assign tick_bit_o = tick_bit_q;
    assign load_ack_o = ack_q;
    assign div_busy_o = busy_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Bench for uart_frac_baud_gen: per-cycle reference model under random stimulus,
// a table of divisor/span vectors, and directed reload/sync/enable/reset sequences.
module tb_uart_frac_baud_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0, sync = 1'b0, load = 1'b0;
    logic [DIV_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              tick_os, tick_bit, load_ack, div_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    uart_frac_baud_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .sync_i     (sync),
        .load_i     (load),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .tick_os_o  (tick_os),
        .tick_bit_o (tick_bit),
        .load_ack_o (load_ack),
        .div_busy_o (div_busy)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed clocks in the current period, fractional accumulator as an
    // integer, bit ticks derived from the running tick count relative to the last phase anchor.
    int m_I = 27, m_F = 2, p_I = 0, p_F = 0;
    int m_el = 0, m_acc = 0, m_ext = 0, m_n = 0, m_off = 0;
    bit m_busy = 0, e_os = 0, e_bit = 0, e_ack = 0;
    int m_per, m_tot;
    bit m_wrap, m_apply;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_I = 27; m_F = 2; m_busy = 0;
            m_el = 0; m_acc = 0; m_ext = 0; m_n = 0; m_off = 0;
            e_os = 0; e_bit = 0; e_ack = 0;
        end else begin
            m_per  = ((m_I == 0) ? 1 : m_I) + m_ext;
            m_wrap = en && !sync && (m_el == m_per - 1);
            e_os = 0; e_bit = 0; e_ack = 0;
            if (sync) begin
                m_el = 0; m_acc = 0; m_ext = 0; m_n = 0; m_off = OS / 2;
            end else if (en) begin
                if (m_wrap) begin
                    m_el  = 0;
                    e_os  = 1;
                    m_tot = m_acc + m_F;
                    m_ext = m_tot / (1 << FRAC_W);
                    m_acc = m_tot % (1 << FRAC_W);
                    m_n++;
                    e_bit = ((m_n + m_off) % OS) == 0;
                end else begin
                    m_el = (m_el + 1) % (1 << (DIV_W + 1));
                end
            end
            m_apply = (load || m_busy) && (sync || !en || m_wrap);
            if (m_apply) begin
                m_I = load ? int'(div_int) : p_I;
                m_F = load ? int'(div_frac) : p_F;
                m_busy = 0;
                e_ack = 1;
            end else if (load) begin
                p_I = int'(div_int);
                p_F = int'(div_frac);
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_tests++;
            if ({tick_os, tick_bit, load_ack, div_busy} !== {e_os, e_bit, e_ack, m_busy}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t os/bit/ack/busy got %b%b%b%b expected %b%b%b%b",
                         $time, tick_os, tick_bit, load_ack, div_busy, e_os, e_bit, e_ack, m_busy);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edges waited (sampled at negedge) until the selected output is high; -1 on timeout.
    task automatic wait_sig(input int which, input int limit, output int n);
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = (which == 0) ? tick_os : (which == 1) ? tick_bit : load_ack;
        end while (!s && n < limit);
        if (!s) n = -1;
    endtask

    task automatic sync_load(input int di, input int df);
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        load = 1'b1;
        sync = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync = 1'b0;
    endtask

    typedef struct {
        int di;
        int df;
        int first;
        int span;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n, acc_ticks, sum, r;
        vecs[0] = '{4, 0, 4, 64};
        vecs[1] = '{3, 8, 3, 56};
        vecs[2] = '{0, 0, 1, 16};
        vecs[3] = '{1, 0, 1, 16};
        vecs[4] = '{27, 2, 27, 434};
        vecs[5] = '{5, 15, 5, 95};
        vecs[6] = '{2, 1, 2, 33};

        repeat (3) @(negedge clk);
        chk("reset_tick_os", tick_os, 0);
        chk("reset_tick_bit", tick_bit, 0);
        chk("reset_load_ack", load_ack, 0);
        chk("reset_div_busy", div_busy, 0);
        chk_on = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Load while disabled applies on the next edge; then count from cnt=0
        div_int = DIV_W'(4); div_frac = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load_en0_ack", load_ack, 1);
        chk("load_en0_busy", div_busy, 0);
        en = 1'b1;
        wait_sig(0, 100, n); chk("div4_first_tick", n, 4);
        wait_sig(1, 200, n); chk("div4_first_bit", n, 60);
        wait_sig(1, 200, n); chk("div4_bit_period", n, 64);

        foreach (vecs[i]) begin
            sync_load(vecs[i].di, vecs[i].df);
            chk($sformatf("vec%0d_ack", i), load_ack, 1);
            chk($sformatf("vec%0d_no_tick_on_sync", i), tick_os, 0);
            wait_sig(0, 100, n);
            chk($sformatf("vec%0d_first", i), n, vecs[i].first);
            sum = 0;
            for (int k = 0; k < 16; k++) begin
                wait_sig(0, 100, n);
                sum += (n < 0) ? 100000 : n;
            end
            chk($sformatf("vec%0d_span16", i), sum, vecs[i].span);
        end

        // Reload mid-period: current period completes at old divisor
        sync_load(4, 0);
        wait_sig(0, 100, n);
        div_int = DIV_W'(10); div_frac = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("reload_busy", div_busy, 1);
        chk("reload_no_ack_yet", load_ack, 0);
        wait_sig(0, 100, n);
        chk("reload_old_period_rest", n, 3);
        chk("reload_ack_with_tick", load_ack, 1);
        chk("reload_busy_cleared", div_busy, 0);
        wait_sig(0, 100, n);
        chk("reload_new_period", n, 10);

        // Sync at arbitrary phase
        sync_load(4, 0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_no_tick", tick_os, 0);
        wait_sig(1, 200, n); chk("sync_first_bit", n, 32);
        wait_sig(1, 200, n); chk("sync_bit_period", n, 64);

        // DIV=0 and DIV=1: tick every clock
        for (int d = 0; d < 2; d++) begin
            sync_load(d, 0);
            acc_ticks = 0;
            repeat (5) begin
                @(negedge clk);
                acc_ticks += tick_os;
            end
            chk($sformatf("div%0d_every_clock", d), acc_ticks, 5);
        end

        // Enable gap mid-period loses no count
        sync_load(10, 0);
        repeat (3) @(negedge clk);
        en = 1'b0;
        acc_ticks = 0;
        repeat (5) begin
            @(negedge clk);
            acc_ticks += tick_os;
        end
        chk("en_low_no_ticks", acc_ticks, 0);
        en = 1'b1;
        wait_sig(0, 100, n);
        chk("en_resume_rest", n, 7);

        // Reset mid-period with a load pending
        sync_load(4, 0);
        wait_sig(0, 100, n);
        div_int = DIV_W'(9); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("rst_pending_busy", div_busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {tick_os, tick_bit, load_ack, div_busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        acc_ticks = 0;
        for (int k = 1; k <= 9; k++) begin
            wait_sig(0, 100, n);
            acc_ticks += load_ack;
            chk($sformatf("rst_default_period%0d", k), n, (k == 9) ? 28 : 27);
        end
        chk("rst_no_ack", acc_ticks, 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom_range(0, 99);
            sync = (r < 2);
            load = ($urandom_range(0, 99) < 4);
            if (load) begin
                div_int  = DIV_W'($urandom_range(0, 12));
                div_frac = FRAC_W'($urandom);
            end
            en = 1'b1;
            if (!m_busy && !load && $urandom_range(0, 9) == 0) en = 1'b0;
            @(negedge clk);
        end
        sync = 1'b0; load = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
